// File: rtl/exam_stim_sequencer_if.sv
// Bundle of the sequencer's handshake and datapath-facing signals.
// master : the sequencer (drives stim and the result outputs)
// slave  : the surrounding exam datapath / environment
interface exam_stim_sequencer_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 1,
  parameter int CNT_W = 8
);
  logic             start;
  logic [OUT_W-1:0] exp_o;
  logic [OUT_W-1:0] usr_o;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fail_cnt;
  logic [IN_W-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    input  start, exp_o, usr_o,
    output stim, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, exp_o, usr_o,
    input  stim, busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/exam_stim_sequencer.sv
// exam_stim_sequencer: exhaustive, clocked stimulus sweep for the exam
// answer-checking datapath. Each vector is held for SETTLE cycles, then the
// reference and candidate outputs are compared for one cycle. Mismatches are
// counted (saturating) and the first failing vector is captured.
// Optional build macro: EXAM_STOP_ON_FAIL_EN -- the first mismatch ends the
// sweep immediately with stim left on the failing vector.
module exam_stim_sequencer #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  exam_stim_sequencer_if.master  bus
);

  // Settle counter must be at least one bit wide even when SETTLE == 1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]    RELOAD   = CW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IN_W-1:0]  STIM_MAX = {IN_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  // Sticky "any mismatch this sweep"; pass relies on it because fail_cnt saturates.
  logic             any_q, any_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic             mismatch_s;

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    ffv_d      = ffv_q;
    ffvalid_d  = ffvalid_q;
    any_d      = any_q;
    settle_d   = settle_q;
    mismatch_s = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          stim_d    = {IN_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          ffv_d     = {IN_W{1'b0}};
          ffvalid_d = 1'b0;
          any_d     = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          settle_d  = RELOAD;
          state_d   = S_APPLY;
        end else begin
          state_d = state_q;
        end
      end

      S_APPLY: begin
        if (settle_q != {CW{1'b0}}) begin
          settle_d = settle_q - CW'(1'b1);
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        // Operand buses are only looked at here, so X elsewhere is harmless.
        mismatch_s = (bus.exp_o != bus.usr_o);
        if (mismatch_s) begin
          any_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end else begin
            cnt_d = cnt_q;
          end
          if (!ffvalid_q) begin
            ffv_d     = stim_q;
            ffvalid_d = 1'b1;
          end else begin
            ffv_d = ffv_q;
          end
        end else begin
          any_d = any_q;
        end
`ifdef EXAM_STOP_ON_FAIL_EN
        if (mismatch_s) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (stim_q == STIM_MAX) begin
`else
        if (stim_q == STIM_MAX) begin
`endif
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~(any_q | mismatch_s);
        end else begin
          stim_d   = stim_q + IN_W'(1'b1);
          settle_d = RELOAD;
          state_d  = S_APPLY;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stim_q    <= {IN_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      ffv_q     <= {IN_W{1'b0}};
      ffvalid_q <= 1'b0;
      any_q     <= 1'b0;
      settle_q  <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      any_q     <= any_d;
      settle_q  <= settle_d;
    end
  end

  assign bus.stim             = stim_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_cnt         = cnt_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_exam_stim_sequencer.sv
// Scoreboard bench for exam_stim_sequencer: two instances (default sizing and
// IN_W=3/SETTLE=1/CNT_W=1/OUT_W=2) driven from truth tables held in the bench.
module tb_exam_stim_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exam_stim_sequencer_if #(.IN_W(2), .OUT_W(1), .CNT_W(8)) ifa();
  exam_stim_sequencer_if #(.IN_W(3), .OUT_W(2), .CNT_W(1)) ifb();

  exam_stim_sequencer #(.IN_W(2), .OUT_W(1), .SETTLE(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  exam_stim_sequencer #(.IN_W(3), .OUT_W(2), .SETTLE(1), .CNT_W(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // Truth tables of the reference and candidate instances.
  int ra[8], ua[8], rb[8], ub[8];
  assign ifa.exp_o = 1'(ra[int'(ifa.stim)]);
  assign ifa.usr_o = 1'(ua[int'(ifa.stim)]);
  assign ifb.exp_o = 2'(rb[int'(ifb.stim)]);
  assign ifb.usr_o = 2'(ub[int'(ifb.stim)]);

  typedef struct {
    int pass_v; int cnt; int fvec; int fvalid; int stim; int lat; int start_cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int n_cmp = 0;
  int n_fail = 0;
  bit pa_prev = 1'b0;
  bit pb_prev = 1'b0;
  exp_t ea, eb;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference result of one sweep, computed from the list of mismatching vectors.
  function automatic exp_t model(input int in_w, input int settle, input int cnt_w,
                                 input int r[8], input int u[8]);
    exp_t e;
    int n, count, first, maxc;
    n = 1 << in_w;
    maxc = (1 << cnt_w) - 1;
    count = 0;
    first = -1;
    for (int v = 0; v < n; v++) begin
      if (r[v] != u[v]) begin
        count++;
        if (first < 0) first = v;
      end
    end
    e.start_cyc = 0;
`ifdef EXAM_STOP_ON_FAIL_EN
    if (count > 0) begin
      e.pass_v = 0; e.cnt = 1; e.fvec = first; e.fvalid = 1; e.stim = first;
      e.lat = (first + 1) * (settle + 1);
      return e;
    end
`endif
    e.pass_v = (count == 0) ? 1 : 0;
    e.cnt    = (count > maxc) ? maxc : count;
    e.fvec   = (first < 0) ? 0 : first;
    e.fvalid = (first < 0) ? 0 : 1;
    e.stim   = n - 1;
    e.lat    = n * (settle + 1);
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e, input int pass_v,
                              input int cnt, input int fvec, input int fvalid,
                              input int stim, input int busy);
    chk({tag, ".pass"}, pass_v, e.pass_v);
    chk({tag, ".fail_cnt"}, cnt, e.cnt);
    chk({tag, ".first_fail_vec"}, fvec, e.fvec);
    chk({tag, ".first_fail_valid"}, fvalid, e.fvalid);
    chk({tag, ".stim"}, stim, e.stim);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".latency"}, cyc - e.start_cyc, e.lat);
  endtask

  // Monitor for instance A: check the result on every rising edge of done.
  initial begin
    forever begin
      @(negedge clk);
      if (ifa.done === 1'b1 && !pa_prev) begin
        if (qa.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL a.unexpected_done: got done=1 expected no pending sweep");
        end else begin
          ea = qa.pop_front();
          check_result("a", ea, int'(ifa.pass), int'(ifa.fail_cnt), int'(ifa.first_fail_vec),
                       int'(ifa.first_fail_valid), int'(ifa.stim), int'(ifa.busy));
        end
      end
      pa_prev = (ifa.done === 1'b1);
    end
  end

  // Monitor for instance B.
  initial begin
    forever begin
      @(negedge clk);
      if (ifb.done === 1'b1 && !pb_prev) begin
        if (qb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b.unexpected_done: got done=1 expected no pending sweep");
        end else begin
          eb = qb.pop_front();
          check_result("b", eb, int'(ifb.pass), int'(ifb.fail_cnt), int'(ifb.first_fail_vec),
                       int'(ifb.first_fail_valid), int'(ifb.stim), int'(ifb.busy));
        end
      end
      pb_prev = (ifb.done === 1'b1);
    end
  end

  function automatic bit get_done(input int sel);
    return (sel == 0) ? (ifa.done === 1'b1) : (ifb.done === 1'b1);
  endfunction

  // Issue one sweep, push its expectation, wait (bounded) for done.
  task automatic sweep(input int sel, input bit poke_mid);
    exp_t e;
    int waited;
    if (sel == 0) e = model(2, 2, 8, ra, ua);
    else          e = model(3, 1, 1, rb, ub);
    @(negedge clk);
    if (sel == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    e.start_cyc = cyc;
    if (sel == 0) qa.push_back(e); else qb.push_back(e);
    if (poke_mid) begin
      repeat (3) @(negedge clk);
      chk("a.busy_mid", int'(ifa.busy), 1);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
    end
    waited = 0;
    while (!get_done(sel) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!get_done(sel)) begin
      n_cmp++; n_fail++;
      $display("FAIL sweep_timeout: got no done after %0d cycles expected done", waited);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, ".stim"}, int'(ifa.stim), 0);
    chk({tag, ".busy"}, int'(ifa.busy), 0);
    chk({tag, ".done"}, int'(ifa.done), 0);
    chk({tag, ".pass"}, int'(ifa.pass), 0);
    chk({tag, ".fail_cnt"}, int'(ifa.fail_cnt), 0);
    chk({tag, ".first_fail_vec"}, int'(ifa.first_fail_vec), 0);
    chk({tag, ".first_fail_valid"}, int'(ifa.first_fail_valid), 0);
  endtask

  task automatic set_a(input int mode);
    // mode 0: AND2 vs AND2, 1: AND2 vs OR2, 2: AND2 vs XNOR2
    for (int v = 0; v < 8; v++) begin
      ra[v] = (v == 3) ? 1 : 0;
      case (mode)
        1:       ua[v] = (v != 0) ? 1 : 0;
        2:       ua[v] = ((v == 0) || (v == 3)) ? 1 : 0;
        default: ua[v] = ra[v];
      endcase
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    set_a(0);
    for (int v = 0; v < 8; v++) begin rb[v] = 0; ub[v] = 0; end
    repeat (3) @(negedge clk);
    check_reset_a("a.reset");
    chk("b.reset.busy", int'(ifb.busy), 0);
    chk("b.reset.done", int'(ifb.done), 0);
    rst = 1'b0;

    set_a(0); sweep(0, 1'b0);
    set_a(1); sweep(0, 1'b0);
    set_a(0); sweep(0, 1'b1);     // start during busy is ignored
    set_a(2); sweep(0, 1'b0);     // start from DONE
    set_a(1); sweep(0, 1'b0);

    // Reset while holding stim=2 in APPLY.
    set_a(0);
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    waited = 0;
    while (ifa.stim !== 2'd2 && waited < 50) begin @(negedge clk); waited++; end
    chk("a.reach_stim2", int'(ifa.stim), 2);
    rst = 1'b1;
    #1;
    check_reset_a("a.midreset");
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    set_a(1); sweep(0, 1'b0);

    // Instance B: matching 2-bit functions, then every vector differing.
    for (int v = 0; v < 8; v++) begin rb[v] = (v * 3) & 3; ub[v] = rb[v]; end
    sweep(1, 1'b0);
    for (int v = 0; v < 8; v++) begin rb[v] = (v == 7) ? 1 : 0; ub[v] = (~rb[v]) & 3; end
    sweep(1, 1'b0);

    // Randomized truth tables with sparse candidate faults.
    for (int it = 0; it < 24; it++) begin
      for (int v = 0; v < 8; v++) begin
        ra[v] = int'($urandom_range(0, 1));
        ua[v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : ra[v];
        rb[v] = int'($urandom_range(0, 3));
        ub[v] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : rb[v];
      end
      sweep(it % 2, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("a.queue_empty", qa.size(), 0);
    chk("b.queue_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
